memory_256x16: RTL and testbench

//   256-word x 16-bit data/instruction memory for the multicycle RISC datapath.
//   - Single write port, synchronous; single read port, combinational.
//   - Sits between the datapath address register and the instruction/data registers.
//   - Reset clears the whole array so simulation starts from a known state.

---
 rtl/memory_pkg.sv | 20 ++
 rtl/memory_256x16_decode.sv | 47 ++++
 rtl/memory_256x16.sv | 65 ++++++
 tb/tb_memory_256x16.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// ---------------------------------------------------------------------------
// memory_pkg
// Shared sizing constants and types for the 256 x 16 datapath memory.
//   DATA_W : word width in bits
//   ADDR_W : width of the datapath address bus
//   DEPTH  : number of stored words
//   IDX_W  : width of the word index taken from the low address bits
// ---------------------------------------------------------------------------
package memory_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : memory_pkg

// File: rtl/memory_256x16_decode.sv
// ---------------------------------------------------------------------------
// memory_256x16_decode
// Address decoder for the 256 x 16 memory. It turns the datapath address and
// write enable into a word index, an in-range flag and a one-hot write strobe
// that is already qualified by the enable and the range check.
//
// Ports
//   i_addr     in   ADDR_W  datapath word address
//   i_we       in   1       write enable
//   o_index    out  IDX_W   selected word, i_addr[7:0]
//   o_inRange  out  1       address maps onto the array
//   o_wrStrobe out  DEPTH   one-hot write select, all zero when no write
//
// Build option
//   MEM_ADDR_CHECK_EN : when defined, any address with non-zero upper bits is
//                       out of range. Otherwise upper bits alias onto the array.
// ---------------------------------------------------------------------------
module memory_256x16_decode
    import memory_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_inRange,
    output logic [DEPTH-1:0]  o_wrStrobe
);

    assign o_index = i_addr[IDX_W-1:0];

`ifdef MEM_ADDR_CHECK_EN
    assign o_inRange = (i_addr[ADDR_W-1:IDX_W] == '0);
`else
    // Upper bits are deliberately ignored so addresses alias onto the array.
    logic w_unusedUpper;
    assign w_unusedUpper = ^i_addr[ADDR_W-1:IDX_W];
    assign o_inRange     = 1'b1;
`endif

    // One strobe bit per word; gating here keeps the storage loop trivial.
    always_comb begin
        o_wrStrobe = '0;
        if (i_we && o_inRange) begin
            o_wrStrobe[o_index] = 1'b1;
        end
    end

endmodule : memory_256x16_decode

// File: rtl/memory_256x16.sv
// ---------------------------------------------------------------------------
// memory_256x16
// 256-word x 16-bit data/instruction memory for the multicycle datapath.
// Synchronous single write port, combinational single read port. The array
// is built from flip-flops so reset can clear every word asynchronously.
//
// Ports
//   clk     in   1   system clock, writes on the rising edge
//   rst     in   1   asynchronous active-high reset, clears the whole array
//   addr    in   16  word address, addr[7:0] selects the word
//   Data    in   16  write data
//   WE      in   1   write enable, sampled on rising clk
//   MemOut  out  16  read data, mem[addr[7:0]] (zero during reset)
//
// Build option
//   MEM_ADDR_CHECK_EN : when defined, addresses with addr[15:8] != 0 neither
//                       write nor read (MemOut = 0). Default: aliasing.
// ---------------------------------------------------------------------------
module memory_256x16
    import memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] Data,
    input  logic              WE,
    output logic [DATA_W-1:0] MemOut
);

    word_t             r_mem [DEPTH];
    logic [IDX_W-1:0]  w_index;
    logic              w_inRange;
    logic [DEPTH-1:0]  w_wrStrobe;
    word_t             w_rdWord;

    memory_256x16_decode u_decode (
        .i_addr     (addr),
        .i_we       (WE),
        .o_index    (w_index),
        .o_inRange  (w_inRange),
        .o_wrStrobe (w_wrStrobe)
    );

    // Whole-array async clear; otherwise each word loads Data on its strobe.
    // Reset has priority, so a write pending during reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wrStrobe[i]) begin
                    r_mem[i] <= Data;
                end
            end
        end
    end

    assign w_rdWord = r_mem[w_index];

    // Forced to zero while reset is held or the address is out of range.
    assign MemOut = (rst || !w_inRange) ? '0 : w_rdWord;

endmodule : memory_256x16

// File: tb/tb_memory_256x16.sv
// ---------------------------------------------------------------------------
// tb_memory_256x16
// Self-checking bench for memory_256x16. Stimulus pushes the expected read
// value into a scoreboard queue; a separate monitor pops and compares it with
// MemOut. The reference is a plain array updated by the memory's rules.
// ---------------------------------------------------------------------------
module tb_memory_256x16;
    import memory_pkg::*;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] Data = 16'h0000;
    logic        WE   = 1'b0;
    logic [15:0] MemOut;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] exp;
    } chk_t;

    chk_t        sbq [$];
    event        chkEv;
    logic [15:0] refMem [256];

    // Clock held low until the reset checks are done, then 10 ns period.
    initial begin
        #20;
        forever #5 clk = ~clk;
    end

    memory_256x16 dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .Data   (Data),
        .WE     (WE),
        .MemOut (MemOut)
    );

    function automatic logic inRange(input logic [15:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return (a[15:8] == 8'h00);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        if (rst || !inRange(a)) return 16'h0000;
        return refMem[a[7:0]];
    endfunction

    function automatic void refWrite(input logic [15:0] a, input logic [15:0] d);
        if (!rst && inRange(a)) refMem[a[7:0]] = d;
    endfunction

    function automatic void refReset();
        for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
    endfunction

    // Monitor: compares every queued expectation against the live output.
    initial begin
        chk_t c;
        forever begin
            @(chkEv);
            while (sbq.size() > 0) begin
                c = sbq.pop_front();
                total++;
                if (MemOut !== c.exp) begin
                    bad++;
                    $display("[TB] FAIL %s addr=%h got=%h want=%h", c.name, c.a, MemOut, c.exp);
                end
            end
        end
    end

    // Queue the expected value for the current address and hold inputs 1 ns.
    task automatic checkOutput(input string name);
        chk_t c;
        c.name = name;
        c.a    = addr;
        c.exp  = refRead(addr);
        sbq.push_back(c);
        ->chkEv;
        #1;
    endtask

    // One write-phase: checks old word before the edge, new word after it.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d,
                                 input logic w, input string name);
        @(negedge clk);
        addr = a;
        Data = d;
        WE   = w;
        #1;
        checkOutput({name, "_pre"});
        @(posedge clk);
        if (w) refWrite(a, d);
        #1;
        checkOutput({name, "_post"});
    endtask

    task automatic readAt(input logic [15:0] a, input string name);
        @(negedge clk);
        addr = a;
        WE   = 1'b0;
        #1;
        checkOutput(name);
    endtask

    initial begin
        logic [15:0] ra;

        // Asynchronous reset, no clock edge involved.
        #1;
        rst = 1'b1;
        refReset();
        addr = 16'h0000;
        #1 checkOutput("rst_00");
        addr = 16'h007F;
        #1 checkOutput("rst_7F");
        addr = 16'h00FF;
        #1 checkOutput("rst_FF");
        #2 rst = 1'b0;
        #1 checkOutput("rstRel_FF");

        // Basic write/read and write-disabled.
        applyStimulus(16'h0012, 16'hBEEF, 1'b1, "basicWr");
        readAt(16'h0013, "basicNeighbor");
        readAt(16'h0012, "basicRd");
        applyStimulus(16'h0012, 16'h1234, 1'b0, "weOff");
        readAt(16'h0012, "weOffRd");

        // Aliasing / range check.
        applyStimulus(16'h0105, 16'hA5A5, 1'b1, "aliasWr");
        readAt(16'h0005, "aliasLo");
        readAt(16'h0105, "aliasHi");

        // Random soak: random phase then a forced write with fresh data.
        for (int it = 0; it < 21; it++) begin
            ra = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) ra[15:8] = 8'($urandom_range(1, 255));
            applyStimulus(ra, 16'($urandom), 1'($urandom), $sformatf("soakA%0d", it));
            applyStimulus(ra, 16'($urandom), 1'b1, $sformatf("soakB%0d", it));
            readAt(16'($urandom_range(0, 255)), $sformatf("soakRd%0d", it));
        end

        // Back-to-back writes to one word: the last one wins.
        applyStimulus(16'h0040, 16'h1111, 1'b1, "b2b1");
        applyStimulus(16'h0040, 16'h2222, 1'b1, "b2b2");
        readAt(16'h0040, "b2bRd");

        // Reset asserted between edges overrides a later write.
        applyStimulus(16'h00FF, 16'hFFFF, 1'b1, "preRst");
        @(negedge clk);
        WE = 1'b0;
        #2;
        rst = 1'b1;
        refReset();
        addr = 16'h00FF;
        #1 checkOutput("rstMid");
        @(negedge clk);
        Data = 16'h1234;
        WE   = 1'b1;
        @(posedge clk);
        #1 checkOutput("rstWrIgnored");
        @(negedge clk);
        WE  = 1'b0;
        rst = 1'b0;
        #1 checkOutput("postRst_FF");
        readAt(16'h0012, "postRst_12");
        readAt(16'h0040, "postRst_40");

        #5;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_memory_256x16
